// File: rtl/ahb_arb_ctrl.sv
// ahb_arb_ctrl -- grant controller for the 5-master AHB arbiter.
//
// Picks the next bus owner from a ranked priority list and holds the grant
// across fixed-length bursts and locked sequences.
//
// Ports:
//   hclk       bus clock (rising edge)
//   hreset     synchronous active-high reset
//   hbusreq    per-master bus request
//   hlock      per-master lock request
//   htrans     transfer type of the current address phase
//   hburst     burst type of the current address phase
//   hready     bus ready; low freezes every register here
//   prio_list  five one-hot rank slots, [24:20] highest
//   hgrant     registered one-hot grant
//   hmaster    registered address-phase owner index
//   hmastlock  registered lock flag of the address-phase transfer
module ahb_arb_ctrl #(
   parameter int DEFAULT_MST = 0
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic [4:0]  hbusreq,
   input  logic [4:0]  hlock,
   input  logic [1:0]  htrans,
   input  logic [2:0]  hburst,
   input  logic        hready,
   input  logic [24:0] prio_list,
   output logic [4:0]  hgrant,
   output logic [2:0]  hmaster,
   output logic        hmastlock
);

   localparam logic [4:0] DEF_GRANT = 5'b00001 << DEFAULT_MST;
   localparam logic [2:0] DEF_IDX   = 3'(DEFAULT_MST);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   typedef enum logic [1:0] {ARB, BURST, LOCKED} state_t;

   state_t     state;
   logic [3:0] beat_cnt;

   function automatic logic is_onehot(input logic [4:0] v);
      return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
   endfunction

   function automatic logic [2:0] oh2idx(input logic [4:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 5; i++)
         if (v[i]) idx = 3'(i);
      return idx;
   endfunction

   // Winner: first well-formed slot that matches a request, else the
   // lowest-index requester, else the default master.
   logic [2:0] win_idx;
   logic       win_found;
   always_comb begin
      win_idx   = DEF_IDX;
      win_found = 1'b0;
      for (int s = 4; s >= 0; s--) begin
         if (!win_found && is_onehot(prio_list[s*5 +: 5]) &&
             ((prio_list[s*5 +: 5] & hbusreq) != 5'd0)) begin
            win_idx   = oh2idx(prio_list[s*5 +: 5]);
            win_found = 1'b1;
         end
      end
      if (!win_found && hbusreq != 5'd0) begin
         // descending scan so the lowest set index is written last
         for (int i = 4; i >= 0; i--)
            if (hbusreq[i]) win_idx = 3'(i);
      end
   end

   logic [4:0] win_oh;
   logic       win_lock;
   logic [2:0] cur_idx;
   logic       burst_start;
   logic [3:0] burst_len_m1;

   assign win_oh      = 5'b00001 << win_idx;
   assign win_lock    = hlock[win_idx] & hbusreq[win_idx];
   assign cur_idx     = oh2idx(hgrant);
   assign burst_start = (htrans == TR_NONSEQ) && (hburst[2:1] != 2'b00);

   always_comb begin
      case (hburst[2:1])
         2'b01:   burst_len_m1 = 4'd3;
         2'b10:   burst_len_m1 = 4'd7;
         2'b11:   burst_len_m1 = 4'd15;
         default: burst_len_m1 = 4'd0;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state     <= ARB;
         beat_cnt  <= 4'd0;
         hgrant    <= DEF_GRANT;
         hmaster   <= DEF_IDX;
         hmastlock <= 1'b0;
      end else if (hready) begin
         // Address-phase owner is whoever held the grant before this edge.
         hmaster   <= cur_idx;
         hmastlock <= hlock[cur_idx];
         case (state)
            ARB: begin
               // A locking winner takes priority over a burst start.
               if (win_lock) begin
                  hgrant <= win_oh;
                  state  <= LOCKED;
               end else if (burst_start) begin
                  beat_cnt <= burst_len_m1;
                  state    <= BURST;
               end else begin
                  hgrant <= win_oh;
               end
            end
            BURST: begin
               case (htrans)
                  TR_SEQ: begin
                     if (beat_cnt <= 4'd1) begin
                        // Last beat: new grant visible while the old owner
                        // still issues it.
                        beat_cnt <= 4'd0;
                        hgrant   <= win_oh;
                        state    <= win_lock ? LOCKED : ARB;
                     end else begin
                        beat_cnt <= beat_cnt - 4'd1;
                     end
                  end
                  TR_BUSY: ;
                  default: begin
                     // IDLE or NONSEQ cut the burst short.
                     beat_cnt <= 4'd0;
                     hgrant   <= win_oh;
                     state    <= win_lock ? LOCKED : ARB;
                  end
               endcase
            end
            LOCKED: begin
               // Release and a fresh lock from the winner hand over directly.
               if (!hlock[cur_idx]) begin
                  hgrant <= win_oh;
                  state  <= win_lock ? LOCKED : ARB;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_arb_ctrl.sv
module tb_ahb_arb_ctrl;

   localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

   logic        hclk = 1'b0;
   logic        hreset, hready;
   logic [4:0]  hbusreq, hlock;
   logic [1:0]  htrans;
   logic [2:0]  hburst;
   logic [24:0] prio_list;
   logic [4:0]  hgrant;
   logic [2:0]  hmaster;
   logic        hmastlock;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [4:0] g;
      logic [2:0] m;
      logic       ml;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];

   ahb_arb_ctrl #(.DEFAULT_MST(0)) dut (
      .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
      .htrans(htrans), .hburst(hburst), .hready(hready), .prio_list(prio_list),
      .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
   );

   always #5 hclk = ~hclk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check();
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      tests++;
      assert (hgrant === e.g) else begin
         fails++;
         $error("FAIL %s hgrant got %b exp %b", t, hgrant, e.g);
      end
      tests++;
      assert (hmaster === e.m) else begin
         fails++;
         $error("FAIL %s hmaster got %0d exp %0d", t, hmaster, e.m);
      end
      tests++;
      assert (hmastlock === e.ml) else begin
         fails++;
         $error("FAIL %s hmastlock got %b exp %b", t, hmastlock, e.ml);
      end
   endtask

   // Drive one cycle, queue what the outputs must be after the edge, check.
   task automatic cyc(input logic rst, input logic rdy, input logic [4:0] br,
                      input logic [4:0] lk, input logic [1:0] tr,
                      input logic [2:0] hb, input logic [4:0] eg,
                      input logic [2:0] em, input logic eml, input string tag);
      exp_t e;
      hreset  = rst;
      hready  = rdy;
      hbusreq = br;
      hlock   = lk;
      htrans  = tr;
      hburst  = hb;
      e.g = eg; e.m = em; e.ml = eml;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge hclk);
      #1;
      check();
   endtask

   initial begin
      prio_list = {5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
      // reset and idle
      cyc(1, 1, 5'b00000, 5'b00000, IDLE, 3'b000, 5'b00001, 3'd0, 1'b0, "rst0");
      cyc(1, 0, 5'b00000, 5'b00000, IDLE, 3'b000, 5'b00001, 3'd0, 1'b0, "rst1");
      cyc(0, 1, 5'b00000, 5'b00000, IDLE, 3'b000, 5'b00001, 3'd0, 1'b0, "idle0");
      cyc(0, 1, 5'b00000, 5'b00000, IDLE, 3'b000, 5'b00001, 3'd0, 1'b0, "idle1");
      // ranking
      prio_list = {5'b00001, 5'b00100, 5'b01000, 5'b10000, 5'b00010};
      cyc(0, 1, 5'b10110, 5'b00000, IDLE, 3'b000, 5'b00100, 3'd0, 1'b0, "rank_g");
      cyc(0, 1, 5'b10110, 5'b00000, IDLE, 3'b000, 5'b00100, 3'd2, 1'b0, "rank_m");
      // malformed top slot skipped, then all-malformed fallback
      prio_list = {5'b00011, 5'b00100, 5'b01000, 5'b10000, 5'b00010};
      cyc(0, 1, 5'b00011, 5'b00000, IDLE, 3'b000, 5'b00010, 3'd2, 1'b0, "bad_slot");
      prio_list = {5{5'b00011}};
      cyc(0, 1, 5'b00011, 5'b00000, IDLE, 3'b000, 5'b00001, 3'd1, 1'b0, "fallback");
      // INCR4 hold, owner drops request mid-burst
      prio_list = {5'b01000, 5'b00010, 5'b00001, 5'b00100, 5'b10000};
      cyc(0, 1, 5'b01010, 5'b00000, IDLE,   3'b000, 5'b01000, 3'd0, 1'b0, "i4_grant");
      cyc(0, 1, 5'b01010, 5'b00000, NONSEQ, 3'b011, 5'b01000, 3'd3, 1'b0, "i4_start");
      cyc(0, 1, 5'b00010, 5'b00000, SEQ,    3'b011, 5'b01000, 3'd3, 1'b0, "i4_seq1");
      cyc(0, 1, 5'b00010, 5'b00000, SEQ,    3'b011, 5'b01000, 3'd3, 1'b0, "i4_seq2");
      cyc(0, 1, 5'b00010, 5'b00000, SEQ,    3'b011, 5'b00010, 3'd3, 1'b0, "i4_seq3");
      cyc(0, 1, 5'b00010, 5'b00000, IDLE,   3'b000, 5'b00010, 3'd1, 1'b0, "i4_after");
      // INCR4 with stall and BUSY
      cyc(0, 1, 5'b01010, 5'b00000, IDLE,   3'b000, 5'b01000, 3'd1, 1'b0, "s_grant");
      cyc(0, 1, 5'b01010, 5'b00000, NONSEQ, 3'b011, 5'b01000, 3'd3, 1'b0, "s_start");
      cyc(0, 1, 5'b00010, 5'b00000, SEQ,    3'b011, 5'b01000, 3'd3, 1'b0, "s_seq1");
      cyc(0, 0, 5'b00010, 5'b00000, IDLE,   3'b000, 5'b01000, 3'd3, 1'b0, "s_stall0");
      cyc(0, 0, 5'b00010, 5'b00000, IDLE,   3'b000, 5'b01000, 3'd3, 1'b0, "s_stall1");
      cyc(0, 1, 5'b00010, 5'b00000, SEQ,    3'b011, 5'b01000, 3'd3, 1'b0, "s_seq2");
      cyc(0, 1, 5'b00010, 5'b00000, BUSY,   3'b011, 5'b01000, 3'd3, 1'b0, "s_busy");
      cyc(0, 1, 5'b00010, 5'b00000, SEQ,    3'b011, 5'b00010, 3'd3, 1'b0, "s_seq3");
      // INCR8 terminated early by IDLE
      cyc(0, 1, 5'b00011, 5'b00000, IDLE,   3'b000, 5'b00010, 3'd1, 1'b0, "i8_grant");
      cyc(0, 1, 5'b00011, 5'b00000, NONSEQ, 3'b101, 5'b00010, 3'd1, 1'b0, "i8_start");
      cyc(0, 1, 5'b00001, 5'b00000, SEQ,    3'b101, 5'b00010, 3'd1, 1'b0, "i8_seq1");
      cyc(0, 1, 5'b00001, 5'b00000, SEQ,    3'b101, 5'b00010, 3'd1, 1'b0, "i8_seq2");
      cyc(0, 1, 5'b00001, 5'b00000, IDLE,   3'b000, 5'b00001, 3'd1, 1'b0, "i8_term");
      // lock on master 4, priority change ignored while locked
      prio_list = {5'b10000, 5'b00001, 5'b00010, 5'b00100, 5'b01000};
      cyc(0, 1, 5'b10001, 5'b10000, IDLE, 3'b000, 5'b10000, 3'd0, 1'b0, "lk_grant");
      prio_list = {5'b00001, 5'b10000, 5'b00010, 5'b00100, 5'b01000};
      cyc(0, 1, 5'b10001, 5'b10000, IDLE, 3'b000, 5'b10000, 3'd4, 1'b1, "lk_hold1");
      cyc(0, 1, 5'b10001, 5'b10000, IDLE, 3'b000, 5'b10000, 3'd4, 1'b1, "lk_hold2");
      // release plus new lock from winner: straight into LOCKED on master 0
      cyc(0, 1, 5'b10001, 5'b00001, IDLE, 3'b000, 5'b00001, 3'd4, 1'b0, "lk_handoff");
      prio_list = {5'b10000, 5'b00001, 5'b00010, 5'b00100, 5'b01000};
      cyc(0, 1, 5'b10001, 5'b00001, IDLE,   3'b000, 5'b00001, 3'd0, 1'b1, "lk0_hold");
      cyc(0, 1, 5'b10001, 5'b00001, NONSEQ, 3'b010, 5'b00001, 3'd0, 1'b1, "lk0_burst");
      cyc(0, 1, 5'b10001, 5'b00000, IDLE,   3'b000, 5'b10000, 3'd0, 1'b0, "lk0_rel");
      // reset during LOCKED, with hready low
      cyc(0, 1, 5'b10001, 5'b10000, IDLE, 3'b000, 5'b10000, 3'd4, 1'b1, "lk4_enter");
      cyc(0, 1, 5'b10001, 5'b10000, IDLE, 3'b000, 5'b10000, 3'd4, 1'b1, "lk4_hold");
      cyc(1, 0, 5'b10001, 5'b10000, IDLE, 3'b000, 5'b00001, 3'd0, 1'b0, "rst_lock");
      cyc(0, 1, 5'b00000, 5'b00000, IDLE, 3'b000, 5'b00001, 3'd0, 1'b0, "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
